data_ram_ctrl: RTL
==================

// Module: data_ram_ctrl
// PURPOSE
//  Parametrised successor data memory for the core's load/store unit: byte-addressed RAM with valid/ready
//  request and response channels, byte-enable stores, sign/zero-extended loads, and fault reporting for
//  misaligned, reserved-mode or out-of-range accesses. Sits between the LSU and the memory array.
// PARAMETERS
//  DEPTH_WORDS  32768  number of 32-bit words; power of two, >=2; IDX_W = $clog2(DEPTH_WORDS)
//  ADDR_W       32     width of req_addr (byte address); must be >= IDX_W+2
// PORTS
//  clk          in   1       single clock, rising edge
//  rstn         in   1       reset: asynchronous, active-HIGH (asserted = 1)
//  req_valid    in   1       request present
//  req_ready    out  1       request accepted when req_valid && req_ready at posedge
//  req_we       in   1       1 = store, 0 = load
//  req_mode     in   3       [1:0] 00 byte, 01 half, 10 word, 11 reserved; [2] 1 = zero-extend load
//  req_addr     in   ADDR_W  byte address
//  req_wdata    in   32      store data, right-aligned (byte in [7:0], half in [15:0])
//  resp_valid   out  1       response present
//  resp_ready   in   1       response consumed when resp_valid && resp_ready at posedge
//  resp_rdata   out  32      load data, extended to 32 bits; 0 for stores and faults
//  resp_err     out  1       access faulted; no memory change occurred
//  busy         out  1       clear sequence in progress
// BEHAVIOUR
//  - Reset (rstn=1): resp_valid=0, resp_rdata=0, resp_err=0, req_ready=0, FSM -> CLEAR (or IDLE, see CONFIG).
//  - FSM states: CLEAR, IDLE. CLEAR writes 0 to word clr_idx each cycle, clr_idx 0..DEPTH_WORDS-1, then IDLE.
//    busy=1 and req_ready=0 throughout CLEAR. Reset asserted mid-CLEAR restarts at clr_idx=0.
//  - IDLE: req_ready = !resp_valid || resp_ready (one response slot; combinational in resp_ready).
//  - Latency: exactly 1 cycle; a request accepted at edge N gives resp_valid=1 after edge N. Back-to-back
//    accepts at full rate when resp_ready=1.
//  - Response held stable (rdata, err) while resp_valid && !resp_ready; resp_valid drops after consume edge
//    unless a new request is accepted on the same edge.
//  - Fault if any: mode[1:0]=11; half with addr[0]=1; word with addr[1:0]!=0; addr[ADDR_W-1:IDX_W+2]!=0.
//    Fault: no write, resp_err=1, resp_rdata=0. Non-fault: resp_err=0.
//  - Store: byte lane = addr[1:0], half lane = addr[1]; only selected bytes written, others preserved.
//  - Load: word read at index addr[IDX_W+1:2]; byte/half extracted from lane; sign-extend from bit 7/15
//    unless mode[2]=1. mode[2] ignored for word and for stores.
//  - Load following a store to the same word on the next accepted cycle returns the new data (store lands
//    at its accept edge; read samples after).
//  - Simultaneous consume and accept in the same cycle: old response retires, new one replaces it, resp_valid stays 1.
// CONFIGURATION
//  DATA_RAM_CLEAR_EN defined: CLEAR state present, post-reset contents all zero, busy high DEPTH_WORDS cycles.
//  Not defined: reset goes straight to IDLE, busy tied 0, array contents undefined after reset (X in sim).
// STRUCTURE
//  Package data_ram_pkg: mode encodings (SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD), UNSIGNED bit index,
//  state enum {ST_CLEAR, ST_IDLE}.
//  Sub-module data_ram_lane (combinational): store lane shift + 4-bit byte-enable generation, and load lane
//  extract + sign/zero extension. Top holds FSM, clear counter, array, response register.
// TESTING
//  1 Reset then wait (CLEAR_EN, DEPTH_WORDS=16): busy=1 for 16 cycles, req_ready=0; then word load addr 0x3C -> rdata 0, err 0.
//  2 Store word 0x8899AABB @0x10, store byte 0x11 @0x12, load word @0x10 -> 0x8811AABB; load byte signed @0x13 -> 0xFFFFFF88; unsigned -> 0x00000088.
//  3 Half store 0xF00D @0x21 -> resp_err=1; load word @0x20 unchanged; mode=11 load -> err=1, rdata=0; addr beyond depth -> err=1.
//  4 Hold resp_ready=0 two cycles with load pending: req_ready=0, resp_rdata stable; release -> next request accepted same edge, no loss/duplication.
//  5 Stream 8 alternating store/load to same word with resp_ready=1: one response per cycle, each load returns prior store's data.
//  6 Assert rstn mid-CLEAR at clr_idx=7: resp_valid=0 immediately; after release full DEPTH_WORDS-cycle clear repeats.

Source files
------------

// File: rtl/data_ram_pkg.sv
// rtl/data_ram_pkg.sv - shared encodings and FSM states for the data RAM controller
package data_ram_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // req_mode bit that selects zero-extension for sub-word loads
    localparam int UNSIGNED = 2;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

endpackage

// File: rtl/data_ram_lane.sv
// rtl/data_ram_lane.sv - byte-lane steering: store replication + byte enables, load extract + extension
module data_ram_lane
    import data_ram_pkg::*;
(
    input  logic [2:0]  mode,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] wdata_sh,
    output logic [3:0]  be,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        be        = 4'b0000;
        wdata_sh  = '0;
        rdata_ext = '0;
        rbyte     = rword[{lane, 3'b000} +: 8];
        rhalf     = lane[1] ? rword[31:16] : rword[15:0];
        case (mode[1:0])
            SZ_BYTE: begin
                // replicate so the selected lane always carries the data; be picks the lane
                be        = 4'b0001 << lane;
                wdata_sh  = {4{wdata[7:0]}};
                rdata_ext = mode[UNSIGNED] ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
            end
            SZ_HALF: begin
                be        = lane[1] ? 4'b1100 : 4'b0011;
                wdata_sh  = {2{wdata[15:0]}};
                rdata_ext = mode[UNSIGNED] ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
            end
            SZ_WORD: begin
                be        = 4'b1111;
                wdata_sh  = wdata;
                rdata_ext = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_ram_ctrl.sv
// rtl/data_ram_ctrl.sv - LSU data RAM with valid/ready request/response and fault reporting
// Optional post-reset zero fill enabled by DATA_RAM_CLEAR_EN.
module data_ram_ctrl
    import data_ram_pkg::*;
#(
    parameter int DEPTH_WORDS = 32768,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_mode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem [DEPTH_WORDS];
    state_t           state, state_nxt;
    logic [IDX_W-1:0] clr_idx;
    logic [IDX_W-1:0] idx;
    logic             accept, fault, wr_en;
    logic [31:0]      wdata_sh, rdata_ext;
    logic [3:0]       be;

`ifdef DATA_RAM_CLEAR_EN
    localparam state_t ST_RESET = ST_CLEAR;
    assign busy = (state == ST_CLEAR);
`else
    localparam state_t ST_RESET = ST_IDLE;
    assign busy = 1'b0;
`endif

    assign idx       = req_addr[IDX_W+1:2];
    assign req_ready = (state == ST_IDLE) && !rstn && (!resp_valid || resp_ready);
    assign accept    = req_valid && req_ready;
    assign fault     = (req_mode[1:0] == SZ_RSVD)
                    || (req_mode[1:0] == SZ_HALF && req_addr[0])
                    || (req_mode[1:0] == SZ_WORD && req_addr[1:0] != 2'b00)
                    || ((req_addr >> (IDX_W + 2)) != '0);
    assign wr_en     = accept && req_we && !fault;

    data_ram_lane u_lane (
        .mode      (req_mode),
        .lane      (req_addr[1:0]),
        .wdata     (req_wdata),
        .rword     (mem[idx]),
        .wdata_sh  (wdata_sh),
        .be        (be),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state   <= ST_RESET;
            clr_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR)
                clr_idx <= clr_idx + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_CLEAR && clr_idx == IDX_W'(DEPTH_WORDS - 1))
            state_nxt = ST_IDLE;
    end

    // Array has no reset; while reset is held the clear just rewrites word 0.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (be[b])
                    mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_err   <= fault;
            resp_rdata <= (fault || req_we) ? '0 : rdata_ext;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

endmodule
